fnd_scan_controller: RTL
========================

// Module: fnd_scan_controller
// PURPOSE
//  Downstream display stage for the 4-bit calculator result (and other binary values).
//  - Latches a binary value on a load strobe.
//  - Converts it to four BCD digits with a sequential double-dabble engine (14 cycles).
//  - Time-multiplexes a 4-digit common-anode FND: one digit active at a time, refreshed by a programmable divider.
// PARAMETERS
//  REFRESH_DIV  100_000  clocks per digit slot (>=2); 100 MHz -> 1 kHz/digit
// PORTS
//  i_clk        in   1  system clock; all state changes on rising edge
//  i_reset      in   1  synchronous, active-high reset
//  i_value      in  14  binary value to display; valid range 0..9999
//  i_load       in   1  1-cycle strobe: capture i_value (ignored while o_busy=1)
//  i_blankZero  in   1  1 = blank leading zeros on digits 3..1 (digit 0 never blanked)
//  o_fndCom     out  4  digit enable, active-low, one-hot; bit0 = ones digit
//  o_fndFont    out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1
//  o_busy       out  1  1 while conversion in progress
//  o_overflow   out  1  1 = last accepted value was >9999
// BEHAVIOUR
//  Reset (i_reset=1 at an edge):
//  - o_fndCom=4'b1111, o_fndFont=8'hFF, o_busy=0, o_overflow=0.
//  - Display BCD regs=0000, digit index=0, divider=0, conversion aborted.
//  Load / conversion FSM: IDLE -> CONV -> IDLE
//  - IDLE, i_load=1: capture i_value, clear shift regs, enter CONV.
//    o_busy=1 from the next edge.
//  - CONV: one double-dabble iteration per clock, 14 iterations.
//    Each iteration: add 3 to each BCD nibble >=5, then shift left 1.
//  - Completion, on the 14th CONV edge:
//    - Display regs are written atomically; all 4 digits update in one cycle.
//    - o_overflow updates; o_busy->0; state returns to IDLE.
//  - Latency: i_load sampled at edge N -> o_busy high N+1..N+14, low at N+15.
//  - i_load while busy: ignored; no queueing; the running conversion is unaffected.
//  - i_load in the same cycle busy falls is accepted (FSM is in IDLE then).
//  - Overflow: i_value>9999 at capture -> conversion still runs its 14 cycles.
//    At completion o_overflow=1 and all digits show dash (8'hBF).
//    The next valid load clears o_overflow at its completion.
//  Scan:
//  - Divider counts 0..REFRESH_DIV-1 and wraps.
//  - On the terminal-count edge, digit index advances 0->1->2->3->0.
//  - o_fndCom and o_fndFont are both registered from the current index and display regs.
//    They change on the same edge; no ghost cycle with mismatched com/font.
//  - o_fndCom: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
//  - First edge after reset release drives idx0 (com=1110).
//  - New display value appears on o_fndFont <=1 clock after o_busy falls, whatever the scan phase.
//  - Scanning never stops during CONV; the old value stays shown until completion.
//  Font (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 dash=BF blank=FF.
//  - Leading-zero blank (i_blankZero=1, no overflow): digit k>0 shows FF if digits k..3 are all 0.
//  - i_blankZero is evaluated live, not latched.
//  Arithmetic: BCD nibbles 4 bits each; 14-bit input shift plus 16-bit BCD = 30-bit working register.
// TESTING (bench uses REFRESH_DIV=4)
//  1. Assert i_reset 3 cycles -> com=1111, font=FF, busy=0, overflow=0.
//     Release -> next edge com=1110, font=C0.
//  2. Load 1234 -> busy high exactly 14 cycles. Then scan repeats, each slot held 4 clocks:
//     1110/99, 1101/B0, 1011/A4, 0111/F9.
//  3. Load 7 with i_blankZero=1 -> 1110/F8; digits 1..3 FF.
//     Drop i_blankZero -> digits 1..3 C0.
//  4. Load 10000 -> overflow=1, all four slots BF.
//     Load 9999 -> overflow=0, all slots 90.
//  5. Load 5678, pulse i_load=4321 at busy cycle 5 -> displays 5678.
//     Load on the cycle busy falls -> accepted.
//  6. Load 1234, assert i_reset at busy cycle 7 -> busy=0, display 0000, com=1111.
//     No 1234 ever shown.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: latches a binary value, converts it to BCD by sequential double-dabble,
// and time-multiplexes it onto a 4-digit common-anode seven-segment display.
module fnd_scan_controller #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_blankZero,
    output logic [3:0]  o_fndCom,
    output logic [7:0]  o_fndFont,
    output logic        o_busy,
    output logic        o_overflow
);
    localparam int DW = $clog2(REFRESH_DIV);

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state_q, state_d;
    logic [3:0]    iter_q, iter_d;
    logic [29:0]   work_q, work_d;
    logic          cap_ovf_q, cap_ovf_d;
    logic [15:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    font_q, font_d;
    logic          busy_q, busy_d;
    logic [15:0]   adj;
    logic [29:0]   step;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hBF;
        endcase
    endfunction

    always_comb begin
        adj = '0;
        for (int k = 0; k < 4; k++)
            adj[4*k +: 4] = work_q[14+4*k +: 4] >= 4'd5 ? work_q[14+4*k +: 4] + 4'd3 : work_q[14+4*k +: 4];
        step = {adj[14:0], work_q[13:0], 1'b0};
        state_d   = state_q;
        iter_d    = iter_q;
        work_d    = work_q;
        cap_ovf_d = cap_ovf_q;
        disp_d    = disp_q;
        ovf_d     = ovf_q;
        if (state_q == IDLE) begin
            if (i_load) begin
                state_d   = CONV;
                iter_d    = 4'd0;
                work_d    = {16'd0, i_value};
                cap_ovf_d = i_value > 14'd9999;
            end
        end else begin
            work_d = step;
            iter_d = iter_q + 4'd1;
            // Last iteration: publish all four digits and the overflow flag together
            if (iter_q == 4'd13) begin
                state_d = IDLE;
                disp_d  = step[29:14];
                ovf_d   = cap_ovf_q;
            end
        end
        busy_d = state_d == CONV;
        div_d  = div_q == DW'(REFRESH_DIV - 1) ? '0 : div_q + 1'b1;
        idx_d  = div_q == DW'(REFRESH_DIV - 1) ? idx_q + 2'd1 : idx_q;
        digit  = disp_q[{idx_q, 2'b00} +: 4];
        blank  = i_blankZero && !ovf_q && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'd0;
        com_d  = ~(4'b0001 << idx_q);
        font_d = ovf_q ? 8'hBF : blank ? 8'hFF : seg(digit);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            work_q    <= '0;
            cap_ovf_q <= 1'b0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            idx_q     <= '0;
            div_q     <= '0;
            com_q     <= 4'b1111;
            font_q    <= 8'hFF;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            work_q    <= work_d;
            cap_ovf_q <= cap_ovf_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            com_q     <= com_d;
            font_q    <= font_d;
            busy_q    <= busy_d;
        end
    end

    assign o_fndCom   = com_q;
    assign o_fndFont  = font_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
endmodule
